// File: rtl/proc_run_ctrl_pkg.sv
// Shared types for the processor run/step sequencer.
// State encoding is visible on the debug State port.
package proc_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_BREAK = 2'd3
  } run_state_e;

  localparam int unsigned PC_W_DEF    = 7;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned RUN_DIV_DEF = 25000000;

  function automatic logic is_active(
    input run_state_e s
  );
    return (s == ST_RUN) || (s == ST_BURST);
  endfunction

endpackage

// File: rtl/proc_run_ctrl_if.sv
// Key-strobe / PC inputs and enable / status outputs
// of the run/step sequencer.
interface proc_run_ctrl_if #(
  parameter int unsigned PC_W  = 7,
  parameter int unsigned CNT_W = 8
);

  logic             StepStrobe;
  logic             RunStrobe;
  logic             BurstStrobe;
  logic [CNT_W-1:0] BurstCount;
  logic             BreakEn;
  logic [PC_W-1:0]  BreakPC;
  logic [PC_W-1:0]  PC;
  logic             ProcEnable;
  logic             Running;
  logic             AtBreak;
  logic [15:0]      CycleCount;
  logic [1:0]       State;

  modport master (
    output StepStrobe,
    output RunStrobe,
    output BurstStrobe,
    output BurstCount,
    output BreakEn,
    output BreakPC,
    output PC,
    input  ProcEnable,
    input  Running,
    input  AtBreak,
    input  CycleCount,
    input  State
  );

  modport slave (
    input  StepStrobe,
    input  RunStrobe,
    input  BurstStrobe,
    input  BurstCount,
    input  BreakEn,
    input  BreakPC,
    input  PC,
    output ProcEnable,
    output Running,
    output AtBreak,
    output CycleCount,
    output State
  );

endinterface

// File: rtl/proc_run_ctrl_tick_divider.sv
// Rate divider: one tick every RUN_DIV enabled clocks.
// Clearing counts the clear cycle itself as the first one.
module tick_divider #(
  parameter int unsigned RUN_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned DIV_W =
    (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TOP =
    DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LOAD =
    (RUN_DIV > 1) ? DIV_W'(1) : '0;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  assign tick_o = en_i && (div_q == DIV_TOP);

  always_comb begin
    div_d = div_q;
    if (clear_i) begin
      div_d = DIV_LOAD;
    end else if (en_i) begin
      div_d = tick_o ? '0 : div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run/step sequencer: turns key strobes into a one-clock
// processor enable (step, burst, free run, PC breakpoint).
module proc_run_ctrl
  import proc_run_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned RUN_DIV = RUN_DIV_DEF
) (
  input logic            Clock,
  input logic            Reset_n,
  proc_run_ctrl_if.slave bus
);

  run_state_e       state_q;
  logic             pe_q;
  logic             run_q;
  logic             brk_q;
  logic             skip_q;
  logic [15:0]      cyc_q;
  logic [CNT_W-1:0] rem_q;

  logic burst_go;
  logic start;
  logic active;
  logic tick;
  logic hit;

  assign burst_go = bus.BurstStrobe && (bus.BurstCount != '0);
  assign active   = is_active(state_q);
  assign start    = !active && (bus.RunStrobe || burst_go);
  assign hit      = bus.BreakEn && (bus.PC == bus.BreakPC)
                    && !skip_q;

  tick_divider #(
    .RUN_DIV(RUN_DIV)
  ) u_div (
    .clk_i  (Clock),
    .rst_ni (Reset_n),
    .clear_i(start),
    .en_i   (active),
    .tick_o (tick)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      pe_q    <= 1'b0;
      run_q   <= 1'b0;
      brk_q   <= 1'b0;
      skip_q  <= 1'b0;
      cyc_q   <= '0;
      rem_q   <= '0;
    end else begin
      pe_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_BREAK: begin
          if (bus.RunStrobe) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
            brk_q   <= 1'b0;
            skip_q  <= (state_q == ST_BREAK);
          end else if (burst_go) begin
            state_q <= ST_BURST;
            rem_q   <= bus.BurstCount;
            run_q   <= 1'b1;
            brk_q   <= 1'b0;
            skip_q  <= (state_q == ST_BREAK);
          end else if (bus.StepStrobe) begin
            pe_q  <= 1'b1;
            cyc_q <= cyc_q + 16'd1;
          end
        end
        ST_RUN, ST_BURST: begin
          // Halt wins over a tick landing in the same cycle.
          if (bus.RunStrobe) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
          end else if (tick && hit) begin
            state_q <= ST_BREAK;
            run_q   <= 1'b0;
            brk_q   <= 1'b1;
          end else if (tick) begin
            pe_q   <= 1'b1;
            cyc_q  <= cyc_q + 16'd1;
            skip_q <= 1'b0;
            if (state_q == ST_BURST) begin
              rem_q <= rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                state_q <= ST_IDLE;
                run_q   <= 1'b0;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ProcEnable = pe_q;
  assign bus.Running    = run_q;
  assign bus.AtBreak    = brk_q;
  assign bus.CycleCount = cyc_q;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl, RUN_DIV=4,
// with a PC model that advances on every ProcEnable.
module tb_proc_run_ctrl;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;
  int   tests   = 0;
  int   fails   = 0;

  proc_run_ctrl_if #(.PC_W(7), .CNT_W(8)) bus ();

  proc_run_ctrl #(
    .PC_W   (7),
    .CNT_W  (8),
    .RUN_DIV(4)
  ) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (bus.slave)
  );

  always #5 Clock = ~Clock;

  logic [6:0] pc_q;
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) pc_q <= '0;
    else if (bus.ProcEnable) pc_q <= pc_q + 7'd1;
  end
  assign bus.PC = pc_q;

  typedef struct {
    logic       step;
    logic       run;
    logic       burst;
    logic [7:0] cnt;
    logic       pe;
    logic [1:0] st;
    logic       running;
    logic [15:0] cc;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic clr_in();
    bus.StepStrobe  = 1'b0;
    bus.RunStrobe   = 1'b0;
    bus.BurstStrobe = 1'b0;
    bus.BurstCount  = 8'd0;
  endtask

  task automatic do_reset();
    clr_in();
    bus.BreakEn = 1'b0;
    bus.BreakPC = 7'd0;
    Reset_n = 1'b0;
    repeat (2) cyc();
    Reset_n = 1'b1;
    cyc();
  endtask

  task automatic quiet(input int n, input string nm);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (bus.ProcEnable) seen++;
    end
    chk(nm, seen, 0);
  endtask

  task automatic wait_pe(input int budget, input string nm,
                         output int n);
    n = 0;
    while (n < budget) begin
      cyc();
      clr_in();
      n++;
      if (bus.ProcEnable) break;
    end
    chk(nm, bus.ProcEnable, 1);
  endtask

  int n;

  initial begin
    clr_in();
    bus.BreakEn = 1'b0;
    bus.BreakPC = 7'd0;
    tbl[0]  = '{0, 0, 0, 8'd0, 0, 2'd0, 0, 16'd0};
    tbl[1]  = '{1, 0, 0, 8'd0, 1, 2'd0, 0, 16'd1};
    tbl[2]  = '{0, 0, 0, 8'd0, 0, 2'd0, 0, 16'd1};
    tbl[3]  = '{1, 1, 0, 8'd0, 0, 2'd1, 1, 16'd1};
    tbl[4]  = '{0, 0, 0, 8'd0, 0, 2'd1, 1, 16'd1};
    tbl[5]  = '{0, 0, 0, 8'd0, 0, 2'd1, 1, 16'd1};
    tbl[6]  = '{0, 0, 0, 8'd0, 1, 2'd1, 1, 16'd2};
    tbl[7]  = '{0, 0, 0, 8'd0, 0, 2'd1, 1, 16'd2};
    tbl[8]  = '{0, 1, 0, 8'd0, 0, 2'd0, 0, 16'd2};
    tbl[9]  = '{0, 0, 0, 8'd0, 0, 2'd0, 0, 16'd2};
    tbl[10] = '{0, 0, 1, 8'd0, 0, 2'd0, 0, 16'd2};
    tbl[11] = '{0, 0, 0, 8'd0, 0, 2'd0, 0, 16'd2};

    // reset state
    repeat (2) cyc();
    chk("rst pe", bus.ProcEnable, 0);
    chk("rst state", bus.State, 0);
    chk("rst running", bus.Running, 0);
    chk("rst atbreak", bus.AtBreak, 0);
    chk("rst cc", bus.CycleCount, 0);
    Reset_n = 1'b1;
    quiet(20, "idle quiet");

    // step, run+step priority, halt, zero burst
    for (int i = 0; i < 12; i++) begin
      bus.StepStrobe  = tbl[i].step;
      bus.RunStrobe   = tbl[i].run;
      bus.BurstStrobe = tbl[i].burst;
      bus.BurstCount  = tbl[i].cnt;
      cyc();
      clr_in();
      chk($sformatf("v%0d pe", i), bus.ProcEnable, tbl[i].pe);
      chk($sformatf("v%0d state", i), bus.State, tbl[i].st);
      chk($sformatf("v%0d running", i), bus.Running,
          tbl[i].running);
      chk($sformatf("v%0d cc", i), bus.CycleCount, tbl[i].cc);
    end
    quiet(12, "after halt quiet");

    // burst of 3
    do_reset();
    bus.BurstCount  = 8'd3;
    bus.BurstStrobe = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_pe(8, $sformatf("burst p%0d", k), n);
      chk($sformatf("burst gap%0d", k), n, 4);
      chk($sformatf("burst st%0d", k), bus.State,
          (k == 2) ? 0 : 2);
    end
    chk("burst cc", bus.CycleCount, 3);
    chk("burst running", bus.Running, 0);
    quiet(20, "burst end quiet");

    // breakpoint at PC 5
    do_reset();
    bus.BreakEn   = 1'b1;
    bus.BreakPC   = 7'd5;
    bus.RunStrobe = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_pe(8, $sformatf("brk p%0d", k), n);
      chk($sformatf("brk gap%0d", k), n, 4);
      chk($sformatf("brk pc%0d", k), pc_q, k);
    end
    quiet(4, "brk hit no pulse");
    chk("brk atbreak", bus.AtBreak, 1);
    chk("brk state", bus.State, 3);
    chk("brk running", bus.Running, 0);
    quiet(20, "brk hold quiet");
    chk("brk pc hold", pc_q, 5);
    bus.RunStrobe = 1'b1;
    wait_pe(8, "resume p", n);
    chk("resume gap", n, 4);
    chk("resume pc", pc_q, 5);
    cyc();
    chk("resume pc next", pc_q, 6);
    chk("resume running", bus.Running, 1);
    chk("resume state", bus.State, 1);
    chk("resume cc", bus.CycleCount, 6);
    wait_pe(8, "resume p2", n);
    chk("resume gap2", n, 3);
    chk("resume st2", bus.State, 1);
    bus.RunStrobe = 1'b1;
    cyc();
    clr_in();
    chk("resume halt", bus.State, 0);
    quiet(20, "resume halt quiet");

    // async reset mid-burst
    do_reset();
    bus.BurstCount  = 8'd4;
    bus.BurstStrobe = 1'b1;
    wait_pe(8, "mid p0", n);
    wait_pe(8, "mid p1", n);
    Reset_n = 1'b0;
    #1;
    chk("async pe", bus.ProcEnable, 0);
    chk("async state", bus.State, 0);
    chk("async running", bus.Running, 0);
    chk("async cc", bus.CycleCount, 0);
    repeat (2) cyc();
    Reset_n = 1'b1;
    quiet(20, "post rst quiet");
    chk("post rst state", bus.State, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
